toggle_event_rx: RTL and testbench

TOGGLE_EVENT_RX -- requirements
Module: toggle_event_rx

---
 rtl/toggle_pkg.sv | 12 +
 rtl/toggle_dff.sv | 14 +
 rtl/toggle_sync.sv | 26 ++
 rtl/toggle_event_rx.sv | 120 ++++++++++++
 tb/tb_toggle_event_rx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/toggle_pkg.sv
// Shared constants and FSM encoding for the toggle-event receiver.
package toggle_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/toggle_dff.sv
// Plain D flip-flop with asynchronous active-low clear, the building block of the synchronizer.
module toggle_dff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= 1'b0;
        else        q <= d;
    end

endmodule

// File: rtl/toggle_sync.sv
// SYNC_STAGES-deep synchronizer chain built from toggle_dff; q is the last stage.
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES:0] chain;

    assign chain[0] = d;

    for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_stage
        toggle_dff u_dff (
            .clk   (clk),
            .reset (reset),
            .d     (chain[i]),
            .q     (chain[i+1])
        );
    end

    assign q = chain[SYNC_STAGES];

endmodule

// File: rtl/toggle_event_rx.sv
// Receives a toggle-encoded event line and accumulates a saturating pending-event count.
// Optional macro TOGGLE_EVENT_RX_GLITCH_FILTER_EN: events need two consecutive cycles of difference.
//
// state | meaning
// INIT  | sync chain settling; prev tracks line_level, no events
// RUN   | each confirmed level change of line_level is one event
module toggle_event_rx
    import toggle_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic [CNT_W-1:0] evt_count,
    output logic             overflow,
    output logic             line_level
);

    localparam int               INIT_W    = $clog2(SYNC_STAGES_MAX + 1);
    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]  PEND_MAX  = '1;

    rx_state_t         state, state_nxt;
    logic [INIT_W-1:0] init_cnt, init_cnt_nxt;
    logic              prev;
    logic [CNT_W-1:0]  pend;
    logic              in_run;
    logic              diff;
    logic              evt;
    logic              accept;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (t_in),
        .q     (line_level)
    );

    // INIT holds for SYNC_STAGES+1 cycles: down-counter from SYNC_STAGES to 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            init_cnt <= INIT_LOAD;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        case (state)
            INIT: begin
                if (init_cnt == '0) state_nxt = RUN;
                else                init_cnt_nxt = init_cnt - 1'b1;
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    assign in_run = (state == RUN);
    assign diff   = (line_level != prev);

`ifdef TOGGLE_EVENT_RX_GLITCH_FILTER_EN
    logic diff_q;

    assign evt = in_run & diff & diff_q;

    // prev only moves on a confirmed event so a one-cycle pulse leaves no trace
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev   <= 1'b0;
            diff_q <= 1'b0;
        end else begin
            diff_q <= in_run & diff & ~evt;
            if (!in_run || evt) prev <= line_level;
        end
    end
`else
    assign evt = in_run & diff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev <= 1'b0;
        else        prev <= line_level;
    end
`endif

    assign evt_valid = (pend != '0);
    assign evt_count = pend;
    assign accept    = evt_valid & evt_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
        end else if (accept) begin
            pend <= evt ? CNT_W'(1) : '0;
        end else if (evt && pend != PEND_MAX) begin
            pend <= pend + CNT_W'(1);
        end
    end

    // a saturating event wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (evt && !accept && pend == PEND_MAX) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Randomized and directed checks of toggle_event_rx against an event-counting reference model.
module tb_toggle_event_rx;

    localparam int S     = 2;
    localparam int W     = 4;
    localparam int MAXC  = (1 << W) - 1;
`ifdef TOGGLE_EVENT_RX_GLITCH_FILTER_EN
    localparam int LAT   = 3;
`else
    localparam int LAT   = 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         t_in = 1'b0;
    logic         evt_ready = 1'b0;
    logic         clr_ovf = 1'b0;
    logic         evt_valid;
    logic [W-1:0] evt_count;
    logic         overflow;
    logic         line_level;

    int n_chk = 0;
    int n_bad = 0;

    // reference model state
    bit samp[$];
    int cyc;
    bit ref_lvl;
    bit ll_prev;
    int m_pend;
    bit m_ovf;

    toggle_event_rx #(.SYNC_STAGES(S), .CNT_W(W)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .t_in       (t_in),
        .evt_ready  (evt_ready),
        .clr_ovf    (clr_ovf),
        .evt_valid  (evt_valid),
        .evt_count  (evt_count),
        .overflow   (overflow),
        .line_level (line_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // synchronized level = t_in as sampled S-1 edges before the latest one
    function automatic bit model_ll();
        int idx = samp.size() - S;
        if (idx < 0) return 1'b0;
        return samp[idx];
    endfunction

    task automatic model_clear();
        samp.delete();
        cyc     = 0;
        ref_lvl = 1'b0;
        ll_prev = 1'b0;
        m_pend  = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic step(input bit tin, input bit rdy, input bit clr);
        bit ll, run, evt, acc;
        t_in      = tin;
        evt_ready = rdy;
        clr_ovf   = clr;
        ll  = model_ll();
        run = (cyc >= S + 1);
`ifdef TOGGLE_EVENT_RX_GLITCH_FILTER_EN
        evt = run && (ll != ref_lvl) && (ll_prev != ref_lvl);
`else
        evt = run && (ll != ref_lvl);
`endif
        acc = (m_pend != 0) && rdy;
        @(posedge clk);
        if (evt && !acc && m_pend == MAXC) m_ovf = 1'b1;
        else if (clr)                      m_ovf = 1'b0;
        if (acc)                      m_pend = evt ? 1 : 0;
        else if (evt && m_pend < MAXC) m_pend = m_pend + 1;
        if (!run || evt) ref_lvl = ll;
        ll_prev = ll;
        samp.push_back(tin);
        cyc++;
        #1;
        chk("evt_valid", int'(evt_valid), int'(m_pend != 0));
        chk("evt_count", int'(evt_count), m_pend);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("line_level", int'(line_level), int'(model_ll()));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, int'(evt_valid), 0);
        chk({tag, "_count"}, int'(evt_count), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_level"}, int'(line_level), 0);
    endtask

    // enter reset away from a clock edge, hold across edges, release with t_in=tin
    task automatic do_reset(input bit tin);
        rst_n     = 1'b0;
        t_in      = tin;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        #1;
        check_zero("in_reset");
        model_clear();
        repeat (2) @(posedge clk);
        #3;
        check_zero("in_reset_held");
        rst_n = 1'b1;
    endtask

    initial begin
        bit lvl;

        // release with t_in high: the initial level is never an event
        do_reset(1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("hold_no_evt", int'(evt_valid), 0);
        end
        chk("hold_level", int'(line_level), 1);

        // single toggle latency and accept
        do_reset(1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < LAT; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("lat_early", int'(evt_valid), 0);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("lat_valid", int'(evt_valid), 1);
        chk("lat_count", int'(evt_count), 1);
        step(1'b1, 1'b1, 1'b0);
        chk("accept_clear", int'(evt_count), 0);

        // saturation: 17 toggles 4 cycles apart
        lvl = 1'b1;
        for (int i = 0; i < 17; i++) begin
            lvl = ~lvl;
            repeat (4) step(lvl, 1'b0, 1'b0);
        end
        repeat (4) step(lvl, 1'b0, 1'b0);
        chk("sat_count", int'(evt_count), 15);
        chk("sat_ovf", int'(overflow), 1);
        step(lvl, 1'b0, 1'b1);
        chk("ovf_cleared", int'(overflow), 0);
        chk("sat_hold", int'(evt_count), 15);

        // accept at max with no event, then accept coinciding with an event at 3
        step(lvl, 1'b1, 1'b0);
        chk("drain", int'(evt_count), 0);
        for (int i = 0; i < 3; i++) begin
            lvl = ~lvl;
            repeat (4) step(lvl, 1'b0, 1'b0);
        end
        chk("pre_acc_count", int'(evt_count), 3);
        lvl = ~lvl;
        step(lvl, 1'b0, 1'b0);
        for (int i = 1; i < LAT; i++) step(lvl, 1'b0, 1'b0);
        step(lvl, 1'b1, 1'b0);
        chk("acc_evt_count", int'(evt_count), 1);
        chk("acc_evt_ovf", int'(overflow), 0);

`ifdef TOGGLE_EVENT_RX_GLITCH_FILTER_EN
        step(lvl, 1'b1, 1'b0);
        step(~lvl, 1'b0, 1'b0);
        repeat (6) step(lvl, 1'b0, 1'b0);
        chk("glitch_dropped", int'(evt_valid), 0);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2) == 0) lvl = ~lvl;
            step(lvl, ($urandom_range(5) == 0), ($urandom_range(9) == 0));
        end

        // mid-stream reset with 5 pending: outputs drop before the next edge
        step(lvl, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            lvl = ~lvl;
            repeat (4) step(lvl, 1'b0, 1'b0);
        end
        chk("pre_rst_count", int'(evt_count), 5);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        do_reset(lvl);
        repeat (10) step(lvl, 1'b0, 1'b0);
        chk("post_rst_no_evt", int'(evt_valid), 0);
        repeat (50) begin
            if ($urandom_range(3) == 0) lvl = ~lvl;
            step(lvl, ($urandom_range(3) == 0), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
